// File: rtl/lm07_pkg.sv
// Shared types and constants for the LM07/LM70 read sequencer.
package lm07_pkg;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } lm07_state_t;

  // Default sensor frame length in bits.
  localparam int FRAME_BITS_DEF = 16;

  // Pin positions on the tile's uio bus.
  localparam int CS_BIT  = 0;
  localparam int SCK_BIT = 1;
  localparam int SIO_BIT = 4;

  // Counter width able to hold values 0..n-1, never less than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lm07_read_sequencer_if.sv
// Host-side control/result bundle between the sequencer and the display logic.
interface lm07_read_sequencer_if #(
  parameter int FRAME_BITS = 16
);
  logic                  ena;
  logic                  auto_en;
  logic                  req;
  logic                  busy;
  logic [FRAME_BITS-1:0] temp_data;
  logic                  temp_valid;
  logic [7:0]            frame_cnt;

  // Host drives the controls and consumes the results.
  modport master (
    output ena, auto_en, req,
    input  busy, temp_data, temp_valid, frame_cnt
  );

  // Sequencer consumes the controls and produces the results.
  modport slave (
    input  ena, auto_en, req,
    output busy, temp_data, temp_valid, frame_cnt
  );
endinterface

// File: rtl/lm07_sample_timer.sv
// Periodic sample timer: one-cycle expiry pulse every SAMPLE_PERIOD clocks while enabled.
module lm07_sample_timer
  import lm07_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic expire
);

  localparam int             CNT_W  = cnt_width(SAMPLE_PERIOD);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign expire = en && (cnt_reg == '0);

  // Count down while enabled; reload on expiry, park at the reload value when disabled.
  always_comb begin
    cnt_next = cnt_reg;
    if (!en || (cnt_reg == '0)) begin
      cnt_next = RELOAD;
    end else begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= RELOAD;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/lm07_read_sequencer.sv
// LM07/LM70 SPI read sequencer: serializes host and timer triggers into
// single 16-bit frame reads and publishes each frame with a valid pulse.
module lm07_read_sequencer
  import lm07_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 1000,
  parameter int FRAME_BITS    = FRAME_BITS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  lm07_read_sequencer_if.slave   host,
  input  logic                   sio,
  output logic                   cs,
  output logic                   sck
);

  localparam int                DIV_W     = cnt_width(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_MAX   = DIV_W'(CLK_DIV - 1);
  localparam int                HALF_W    = cnt_width(2 * FRAME_BITS);
  localparam logic [HALF_W-1:0] LAST_HALF = HALF_W'(2 * FRAME_BITS - 1);

  lm07_state_t           state_reg, state_next;
  logic [DIV_W-1:0]      div_cnt_reg, div_cnt_next;
  logic [HALF_W-1:0]     half_cnt_reg, half_cnt_next;
  logic                  sck_reg, sck_next;
  logic [FRAME_BITS-1:0] shift_data_reg, shift_data_next;
  logic [FRAME_BITS-1:0] temp_data_reg, temp_data_next;
  logic [7:0]            frame_cnt_reg, frame_cnt_next;
  logic                  pending_reg, pending_next;
  logic                  timer_expire;
  logic                  trigger_any;

  lm07_sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_sample_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (host.auto_en),
    .expire (timer_expire)
  );

  // A trigger in the very cycle a frame starts is absorbed by that frame.
  assign trigger_any = pending_reg | host.req | timer_expire;

  assign cs              = !((state_reg == SETUP) || (state_reg == SHIFT));
  assign sck             = sck_reg;
  assign host.busy       = (state_reg != IDLE);
  assign host.temp_valid = (state_reg == DONE);
  assign host.temp_data  = temp_data_reg;
  assign host.frame_cnt  = frame_cnt_reg;

  // Next-state and datapath updates for the frame sequencer.
  always_comb begin
    state_next      = state_reg;
    div_cnt_next    = div_cnt_reg;
    half_cnt_next   = half_cnt_reg;
    sck_next        = sck_reg;
    shift_data_next = shift_data_reg;
    temp_data_next  = temp_data_reg;
    frame_cnt_next  = frame_cnt_reg;
    pending_next    = trigger_any;

    unique case (state_reg)
      IDLE: begin
        if (trigger_any && host.ena) begin
          pending_next = 1'b0;
          state_next   = SETUP;
          div_cnt_next = DIV_MAX;
        end
      end
      SETUP: begin
        if (div_cnt_reg == '0) begin
          // First SCK rise: sensor already drives the MSB since CS fell.
          state_next      = SHIFT;
          div_cnt_next    = DIV_MAX;
          half_cnt_next   = '0;
          sck_next        = 1'b1;
          shift_data_next = {shift_data_reg[FRAME_BITS-2:0], sio};
        end else begin
          div_cnt_next = div_cnt_reg - 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt_reg == '0) begin
          div_cnt_next = DIV_MAX;
          if (half_cnt_reg == LAST_HALF) begin
            // Full frame received: publish it atomically with the valid pulse.
            state_next     = DONE;
            sck_next       = 1'b0;
            temp_data_next = shift_data_reg;
            frame_cnt_next = frame_cnt_reg + 8'd1;
          end else begin
            half_cnt_next = half_cnt_reg + 1'b1;
            sck_next      = ~sck_reg;
            if (!sck_reg) begin
              shift_data_next = {shift_data_reg[FRAME_BITS-2:0], sio};
            end
          end
        end else begin
          div_cnt_next = div_cnt_reg - 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath registers: SCK divider, shift register, results and pending flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg    <= '0;
      half_cnt_reg   <= '0;
      sck_reg        <= 1'b0;
      shift_data_reg <= '0;
      temp_data_reg  <= '0;
      frame_cnt_reg  <= '0;
      pending_reg    <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      half_cnt_reg   <= half_cnt_next;
      sck_reg        <= sck_next;
      shift_data_reg <= shift_data_next;
      temp_data_reg  <= temp_data_next;
      frame_cnt_reg  <= frame_cnt_next;
      pending_reg    <= pending_next;
    end
  end

endmodule

// File: tb/tb_lm07_read_sequencer.sv
// Self-checking bench for lm07_read_sequencer with a behavioural LM07 sensor.
module tb_lm07_read_sequencer;

  localparam int CLK_DIV       = 4;
  localparam int SAMPLE_PERIOD = 200;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sio   = 1'b0;
  logic cs;
  logic sck;

  lm07_read_sequencer_if #(.FRAME_BITS(16)) bus ();

  lm07_read_sequencer #(
    .CLK_DIV      (CLK_DIV),
    .SAMPLE_PERIOD(SAMPLE_PERIOD),
    .FRAME_BITS   (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .host (bus),
    .sio  (sio),
    .cs   (cs),
    .sck  (sck)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sensor model: MSB out when CS falls, next bit on every SCK falling edge.
  logic [15:0] sensor_word = 16'h0B9F;
  int          bit_idx = 15;
  logic        cs_q = 1'b1;
  logic        sck_q = 1'b0;
  int          cs_low_total = 0;
  int          sck_rise_total = 0;

  always @(negedge clk) begin
    if (cs) begin
      bit_idx = 15;
    end else begin
      cs_low_total++;
      if (cs_q) begin
        sio = sensor_word[bit_idx];
      end else if (sck_q && !sck) begin
        bit_idx--;
        if (bit_idx >= 0) sio = sensor_word[bit_idx];
      end
      if (!sck_q && sck) sck_rise_total++;
    end
    cs_q  = cs;
    sck_q = sck;
  end

  int          checks = 0;
  int          errors = 0;
  int          exp_frames = 0;
  logic [23:0] exp_q[$];

  task automatic push_expected();
    exp_frames++;
    exp_q.push_back({8'(exp_frames), sensor_word});
  endtask

  task automatic pop_exp(output logic [23:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  task automatic wait_valid(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk);
      #1;
      if (bus.temp_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_req();
    @(posedge clk);
    #1 bus.req = 1'b1;
    @(posedge clk);
    #1 bus.req = 1'b0;
  endtask

  task automatic test_reset();
    bus.ena = 1'b1; bus.auto_en = 1'b0; bus.req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({cs, sck, bus.busy, bus.temp_valid} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_pins: got cs/sck/busy/valid=%b required 1000", {cs, sck, bus.busy, bus.temp_valid});
    end
    checks++;
    if ({bus.frame_cnt, bus.temp_data} !== 24'h0) begin
      errors++;
      $display("FAIL reset_data: got cnt/data=%h required 000000", {bus.frame_cnt, bus.temp_data});
    end
    @(negedge clk) rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_single_read();
    int t0, tv, base_low, base_rise;
    bit ok;
    logic [23:0] e;
    @(posedge clk);
    #1 bus.req = 1'b1;
    t0 = cyc; base_low = cs_low_total; base_rise = sck_rise_total;
    push_expected();
    @(posedge clk);
    #1 bus.req = 1'b0;
    wait_valid(300, ok);
    tv = cyc;
    checks++;
    if (!ok) begin errors++; $display("FAIL single_timeout: got no temp_valid required one within 300 cycles"); end
    checks++;
    if (tv - t0 !== 133) begin errors++; $display("FAIL single_latency: got %0d required 133", tv - t0); end
    pop_exp(e);
    $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
    checks++;
    if ({bus.frame_cnt, bus.temp_data} !== e) begin
      errors++; $display("FAIL single_data: got %h required %h", {bus.frame_cnt, bus.temp_data}, e);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.temp_valid !== 1'b0 || bus.temp_data !== 16'h0B9F) begin
      errors++; $display("FAIL single_pulse: got valid=%b data=%h required 0 0b9f", bus.temp_valid, bus.temp_data);
    end
    checks++;
    if (cs_low_total - base_low !== 132) begin
      errors++; $display("FAIL single_cs_low: got %0d required 132", cs_low_total - base_low);
    end
    checks++;
    if (sck_rise_total - base_rise !== 16) begin
      errors++; $display("FAIL single_sck_rises: got %0d required 16", sck_rise_total - base_rise);
    end
  endtask

  task automatic test_auto();
    int pulses = 0;
    logic [23:0] e;
    for (int k = 0; k < 5; k++) push_expected();
    @(posedge clk);
    #1 bus.auto_en = 1'b1;
    for (int c = 0; c < 1350; c++) begin
      @(posedge clk);
      #1;
      if (c == 1050) bus.auto_en = 1'b0;
      if (bus.temp_valid) begin
        pulses++;
        pop_exp(e);
        $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
        checks++;
        if ({bus.frame_cnt, bus.temp_data} !== e) begin
          errors++; $display("FAIL auto_data: got %h required %h", {bus.frame_cnt, bus.temp_data}, e);
        end
      end
    end
    checks++;
    if (pulses !== 5) begin errors++; $display("FAIL auto_frames: got %0d required 5", pulses); end
    checks++;
    if (bus.frame_cnt !== 8'(exp_frames)) begin
      errors++; $display("FAIL auto_cnt: got %0d required %0d", bus.frame_cnt, 8'(exp_frames));
    end
  endtask

  task automatic test_back_to_back();
    int pulses = 0, gap = 0;
    logic [23:0] e;
    logic [7:0] cnt_before;
    cnt_before = bus.frame_cnt;
    push_expected();
    push_expected();
    @(posedge clk);
    #1 bus.req = 1'b1;
    for (int c = 0; c < 700; c++) begin
      @(posedge clk);
      #1;
      bus.req = (c == 10 || c == 40 || c == 90);
      if (bus.temp_valid) begin
        pulses++;
        pop_exp(e);
        $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
        checks++;
        if ({bus.frame_cnt, bus.temp_data} !== e) begin
          errors++; $display("FAIL b2b_data: got %h required %h", {bus.frame_cnt, bus.temp_data}, e);
        end
      end
      if (pulses == 1 && cs) gap++;
    end
    checks++;
    if (pulses !== 2) begin errors++; $display("FAIL b2b_frames: got %0d required 2", pulses); end
    checks++;
    if (gap < 1 || gap > 4) begin errors++; $display("FAIL b2b_cs_gap: got %0d required 1..4", gap); end
    checks++;
    if (bus.frame_cnt !== cnt_before + 8'd2) begin
      errors++; $display("FAIL b2b_cnt: got %0d required %0d", bus.frame_cnt, cnt_before + 8'd2);
    end
  endtask

  task automatic test_reset_mid_frame();
    int rises = 0;
    logic prev = 1'b0;
    bit ok, saw_valid = 1'b0;
    logic [23:0] e;
    @(posedge clk);
    #1 bus.req = 1'b1;
    for (int c = 0; c < 200 && rises < 8; c++) begin
      @(posedge clk);
      #1 bus.req = 1'b0;
      if (sck && !prev) rises++;
      prev = sck;
    end
    checks++;
    if (rises !== 8) begin errors++; $display("FAIL midrst_rises: got %0d required 8", rises); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs, sck, bus.busy, bus.temp_valid} !== 4'b1000 || bus.temp_data !== 16'h0) begin
      errors++;
      $display("FAIL midrst_abort: got cs/sck/busy/valid=%b data=%h required 1000 0000",
               {cs, sck, bus.busy, bus.temp_valid}, bus.temp_data);
    end
    exp_frames = 0;
    repeat (4) begin
      @(posedge clk);
      #1 if (bus.temp_valid) saw_valid = 1'b1;
    end
    @(negedge clk) rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1 if (bus.temp_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin errors++; $display("FAIL midrst_no_valid: got a temp_valid pulse required none"); end
    push_expected();
    pulse_req();
    wait_valid(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL midrst_timeout: got no temp_valid required one"); end
    pop_exp(e);
    $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
    checks++;
    if ({bus.frame_cnt, bus.temp_data} !== e) begin
      errors++; $display("FAIL midrst_data: got %h required %h", {bus.frame_cnt, bus.temp_data}, e);
    end
  endtask

  task automatic test_ena_gate();
    bit ok, early = 1'b0, started = 1'b0;
    logic [23:0] e;
    push_expected();
    @(posedge clk);
    #1 bus.req = 1'b1;
    push_expected();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      #1;
      bus.req = (c == 25);
      if (c == 20) bus.ena = 1'b0;
    end
    bus.req = 1'b0;
    wait_valid(300, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL ena_timeout: got no temp_valid required one"); end
    pop_exp(e);
    $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
    checks++;
    if ({bus.frame_cnt, bus.temp_data} !== e) begin
      errors++; $display("FAIL ena_data: got %h required %h", {bus.frame_cnt, bus.temp_data}, e);
    end
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #1 if (bus.busy || !cs || bus.temp_valid) early = 1'b1;
    end
    checks++;
    if (early) begin errors++; $display("FAIL ena_hold: got a frame while ena=0 required none"); end
    bus.ena = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1 if (bus.busy && !cs) started = 1'b1;
    end
    checks++;
    if (!started) begin errors++; $display("FAIL ena_restart: got no start within 2 cycles required start"); end
    wait_valid(300, ok);
    pop_exp(e);
    $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
    checks++;
    if (!ok || {bus.frame_cnt, bus.temp_data} !== e) begin
      errors++; $display("FAIL ena_pending_data: got ok=%b %h required %h", ok, {bus.frame_cnt, bus.temp_data}, e);
    end
  endtask

  task automatic test_new_word_and_wrap();
    bit ok, saw_wrap = 1'b0;
    logic [7:0] prev_cnt;
    logic [23:0] e;
    int n;
    sensor_word = 16'h191F;
    n = 256 - (exp_frames % 256) + 1;
    for (int f = 0; f < n; f++) begin
      prev_cnt = bus.frame_cnt;
      push_expected();
      pulse_req();
      wait_valid(300, ok);
      pop_exp(e);
      $display("frame cnt=%0d data=%h", bus.frame_cnt, bus.temp_data);
      checks++;
      if (!ok || {bus.frame_cnt, bus.temp_data} !== e) begin
        errors++; $display("FAIL wrap_frame: got ok=%b %h required %h", ok, {bus.frame_cnt, bus.temp_data}, e);
      end
      if (prev_cnt == 8'd255 && bus.frame_cnt == 8'd0) saw_wrap = 1'b1;
    end
    checks++;
    if (!saw_wrap) begin errors++; $display("FAIL wrap_seen: got no 255->0 step required one"); end
  endtask

  initial begin
    bus.ena = 1'b1; bus.auto_en = 1'b0; bus.req = 1'b0;
    test_reset();
    test_single_read();
    test_auto();
    test_back_to_back();
    test_reset_mid_frame();
    test_ena_gate();
    test_new_word_and_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
